time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/clock_pkg.sv | 69 ++++++
 rtl/btn_edge.sv | 28 ++
 rtl/time_set_ctrl.sv | 130 +++++++++++++
 tb/tb_time_set_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types for the clock time-set controller: FSM states, field bit
// indices and the per-state output decode.
package clock_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_S  = 3'd1,
        SET_MI = 3'd2,
        SET_H  = 3'd3,
        SET_D  = 3'd4
    } state_t;

    localparam int FLD_S  = 0;
    localparam int FLD_MI = 1;
    localparam int FLD_H  = 2;
    localparam int FLD_D  = 3;

    // Level outputs that depend only on state and blink phase
    typedef struct packed {
        logic       pulse_1s;
        logic [3:0] cnt_en;
        logic [3:0] disp;
        logic       set_mode;
    } ctrl_t;

    // One-hot field selected by a SET state, zero in RUN
    function automatic logic [3:0] field_mask(input state_t s);
        logic [3:0] m;
        m = '0;
        case (s)
            SET_S:   m[FLD_S]  = 1'b1;
            SET_MI:  m[FLD_MI] = 1'b1;
            SET_H:   m[FLD_H]  = 1'b1;
            SET_D:   m[FLD_D]  = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

    // Mode button walks RUN -> S -> MI -> H -> D -> RUN
    function automatic state_t mode_next(input state_t s);
        case (s)
            RUN:     return SET_S;
            SET_S:   return SET_MI;
            SET_MI:  return SET_H;
            SET_H:   return SET_D;
            default: return RUN;
        endcase
    endfunction

    function automatic ctrl_t ctrl_for(input state_t s, input logic phase);
        ctrl_t      c;
        logic [3:0] m;
        m = field_mask(s);
        if (s == RUN) begin
            c.pulse_1s = 1'b1;
            c.cnt_en   = 4'b1111;
            c.disp     = 4'b1111;
            c.set_mode = 1'b0;
        end else begin
            c.pulse_1s = 1'b0;
            c.cnt_en   = m;
            c.disp     = ~m | (phase ? m : 4'b0000);
            c.set_mode = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer plus registered rising-edge detector. 'level' is the
// synchronized level aligned with 'rise', which pulses 3 clks after btn rises.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    logic sync1, sync2;

    // Synchronize, then compare against the delayed level for the edge pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            level <= sync2;
            rise  <= sync2 & ~level;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set controller: mode button cycles RUN/SET_S/SET_MI/SET_H/SET_D, up/down
// buttons emit one-clk adjust pulses for the selected field, which blinks.
// Optional build macro AUTO_REPEAT_EN adds hold-to-repeat on up/down.
import clock_pkg::*;

module time_set_ctrl #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int BLINK_CYCLES  = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       enable_pulse_1s,
    output logic [3:0] enable_cnt,
    output logic [3:0] increase,
    output logic [3:0] decrease,
    output logic [3:0] disp_en,
    output logic       set_mode
);

    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [2:0] btn_raw, btn_lvl, btn_rise;
    logic       mode_rise, up_rise, dn_rise, up_lvl, dn_lvl;
    logic       unused_mode_lvl;

    assign btn_raw = {btn_down, btn_up, btn_mode};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        btn_edge u_edge (
            .clk   (clk),
            .rst   (rst),
            .btn   (btn_raw[i]),
            .level (btn_lvl[i]),
            .rise  (btn_rise[i])
        );
    end

    assign mode_rise       = btn_rise[0];
    assign up_rise         = btn_rise[1];
    assign dn_rise         = btn_rise[2];
    assign up_lvl          = btn_lvl[1];
    assign dn_lvl          = btn_lvl[2];
    assign unused_mode_lvl = btn_lvl[0];

    state_t        state, state_nxt;
    logic [BW-1:0] blink_cnt, blink_nxt;
    logic          blink_phase, phase_nxt;
    logic          adj_ok, up_fire, dn_fire;
    ctrl_t         ctrl_q;

    // Adjusts only in SET states, and a mode edge in the same clk wins
    assign adj_ok = (state != RUN) & ~mode_rise;

`ifdef AUTO_REPEAT_EN
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          rpt_fire;

    // Hold counter: first repeat after HOLD_CYCLES, then rewind so the next
    // one lands REPEAT_CYCLES later; any edge, release or state change clears it
    always_comb begin
        hold_nxt = hold_cnt;
        rpt_fire = 1'b0;
        if (!adj_ok || !(up_lvl ^ dn_lvl) || up_rise || dn_rise) begin
            hold_nxt = '0;
        end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            hold_nxt = HW'(HOLD_CYCLES - REPEAT_CYCLES);
            rpt_fire = 1'b1;
        end else begin
            hold_nxt = hold_cnt + HW'(1);
        end
    end

    // Hold counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_cnt <= '0;
        else     hold_cnt <= hold_nxt;
    end

    assign up_fire = adj_ok & ((up_rise & ~dn_lvl) | (rpt_fire & up_lvl));
    assign dn_fire = adj_ok & ((dn_rise & ~up_lvl) | (rpt_fire & dn_lvl));
`else
    assign up_fire = adj_ok & up_rise & ~dn_lvl;
    assign dn_fire = adj_ok & dn_rise & ~up_lvl;
`endif

    // Next state and blink timing; a state change restarts the blink at phase 1
    always_comb begin
        state_nxt = mode_rise ? mode_next(state) : state;
        blink_nxt = blink_cnt + BW'(1);
        phase_nxt = blink_phase;
        if (mode_rise) begin
            blink_nxt = '0;
            phase_nxt = 1'b1;
        end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            blink_nxt = '0;
            phase_nxt = ~blink_phase;
        end
    end

    // FSM with registered outputs decoded from the upcoming state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            increase    <= '0;
            decrease    <= '0;
            ctrl_q      <= ctrl_for(RUN, 1'b1);
        end else begin
            state       <= state_nxt;
            blink_cnt   <= blink_nxt;
            blink_phase <= phase_nxt;
            increase    <= up_fire ? field_mask(state) : 4'b0000;
            decrease    <= dn_fire ? field_mask(state) : 4'b0000;
            ctrl_q      <= ctrl_for(state_nxt, phase_nxt);
        end
    end

    assign enable_pulse_1s = ctrl_q.pulse_1s;
    assign enable_cnt      = ctrl_q.cnt_en;
    assign disp_en         = ctrl_q.disp;
    assign set_mode        = ctrl_q.set_mode;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: adjust pulses go through a scoreboard queue (pushed
// when a press is driven, popped when a pulse appears); level outputs are
// checked inline by each scenario task.
module tb_time_set_ctrl;

    localparam int HOLD = 20;
    localparam int REP  = 5;
    localparam int BLK  = 4;

    logic       clk, rst;
    logic       btn_mode, btn_up, btn_down;
    logic       enable_pulse_1s, set_mode;
    logic [3:0] enable_cnt, increase, decrease, disp_en;

    time_set_ctrl #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .BLINK_CYCLES  (BLK)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .btn_mode        (btn_mode),
        .btn_up          (btn_up),
        .btn_down        (btn_down),
        .enable_pulse_1s (enable_pulse_1s),
        .enable_cnt      (enable_cnt),
        .increase        (increase),
        .decrease        (decrease),
        .disp_en         (disp_en),
        .set_mode        (set_mode)
    );

    typedef struct {
        int         cyc;
        logic [3:0] inc;
        logic [3:0] dec;
    } pulse_t;

    pulse_t sb[$];
    pulse_t mon_p;
    int     cyc = 0;
    int     vec = 0;
    int     miss = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every nonzero adjust cycle must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && ((increase | decrease) != 4'b0000)) begin
            vec++;
            if (sb.size() == 0) begin
                miss++;
                $display("FAIL unexpected_pulse: cyc=%0d inc=%b dec=%b, want no pulse",
                         cyc, increase, decrease);
            end else begin
                mon_p = sb.pop_front();
                if (cyc !== mon_p.cyc || increase !== mon_p.inc || decrease !== mon_p.dec) begin
                    miss++;
                    $display("FAIL pulse: got cyc=%0d inc=%b dec=%b, want cyc=%0d inc=%b dec=%b",
                             cyc, increase, decrease, mon_p.cyc, mon_p.inc, mon_p.dec);
                end
            end
        end
    end

    // Drive a button set m = {down, up, mode} for 'hold' clks; queue the edge
    // pulse and, with rpt set, the auto-repeat pulses the held level implies
    task automatic press(input logic [2:0] m, input int hold, input logic [3:0] ei,
                         input logic [3:0] ed, input bit rpt);
        int c;
        @(posedge clk); #1;
        c = cyc;
        if ((ei | ed) != 4'b0000) begin
            sb.push_back('{c + 4, ei, ed});
`ifdef AUTO_REPEAT_EN
            if (rpt) begin
                for (int t = c + 4 + HOLD; t <= c + hold + 3; t += REP)
                    sb.push_back('{t, ei, ed});
            end
`endif
        end
        btn_mode = m[0];
        btn_up   = m[1];
        btn_down = m[2];
        repeat (hold) @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (8) @(posedge clk);
        vec++;
        if (sb.size() != 0) begin
            miss++;
            $display("FAIL missing_pulses: %0d queued pulses never seen, want 0", sb.size());
            sb.delete();
        end
    endtask

    // Enter the next SET state with a mode press and follow its blink pattern
    task automatic blink_walk(input logic [3:0] m);
        int         c;
        logic       ph;
        logic [3:0] exp;
        @(posedge clk); #1;
        c = cyc;
        btn_mode = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (cyc >= c + 2) btn_mode = 1'b0;
            if (cyc >= c + 4) begin
                ph  = (((cyc - (c + 4)) / BLK) % 2) == 0;
                exp = ~m | (ph ? m : 4'b0000);
                vec++;
                if (disp_en !== exp || enable_cnt !== m) begin
                    miss++;
                    $display("FAIL blink k=%0d: got disp=%b cnt=%b, want disp=%b cnt=%b",
                             k, disp_en, enable_cnt, exp, m);
                end
            end
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        repeat (3) @(negedge clk);
        vec++;
        if (enable_pulse_1s !== 1'b1 || enable_cnt !== 4'b1111 || increase !== 4'b0000 ||
            decrease !== 4'b0000 || disp_en !== 4'b1111 || set_mode !== 1'b0) begin
            miss++;
            $display("FAIL reset_outputs: got p1s=%b cnt=%b inc=%b dec=%b disp=%b set=%b, want 1 1111 0000 0000 1111 0",
                     enable_pulse_1s, enable_cnt, increase, decrease, disp_en, set_mode);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Up/down in RUN must never pulse, and RUN outputs stay put
    task automatic test_run_idle;
        press(3'b010, 3, 4'b0000, 4'b0000, 1'b0);
        press(3'b100, 3, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        vec++;
        if (enable_cnt !== 4'b1111 || enable_pulse_1s !== 1'b1 || set_mode !== 1'b0) begin
            miss++;
            $display("FAIL run_idle: got cnt=%b p1s=%b set=%b, want 1111 1 0",
                     enable_cnt, enable_pulse_1s, set_mode);
        end
    endtask

    task automatic test_set_mi;
        press(3'b001, 2, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        vec++;
        if (enable_cnt !== 4'b0001 || set_mode !== 1'b1 || enable_pulse_1s !== 1'b0) begin
            miss++;
            $display("FAIL set_s: got cnt=%b set=%b p1s=%b, want 0001 1 0",
                     enable_cnt, set_mode, enable_pulse_1s);
        end
        press(3'b001, 2, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        vec++;
        if (enable_cnt !== 4'b0010 || enable_pulse_1s !== 1'b0) begin
            miss++;
            $display("FAIL set_mi: got cnt=%b p1s=%b, want 0010 0", enable_cnt, enable_pulse_1s);
        end
        press(3'b010, 2, 4'b0010, 4'b0000, 1'b0);
        press(3'b100, 3, 4'b0000, 4'b0010, 1'b0);
    endtask

    task automatic test_collide;
        blink_walk(4'b0100);
        press(3'b110, 3, 4'b0000, 4'b0000, 1'b0);
        press(3'b011, 3, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        vec++;
        if (enable_cnt !== 4'b1000 || set_mode !== 1'b1) begin
            miss++;
            $display("FAIL mode_over_up: got cnt=%b set=%b, want 1000 1", enable_cnt, set_mode);
        end
    endtask

    task automatic test_back_to_run;
        press(3'b001, 2, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        vec++;
        if (disp_en !== 4'b1111 || set_mode !== 1'b0 || enable_cnt !== 4'b1111 ||
            enable_pulse_1s !== 1'b1) begin
            miss++;
            $display("FAIL back_to_run: got disp=%b set=%b cnt=%b p1s=%b, want 1111 0 1111 1",
                     disp_en, set_mode, enable_cnt, enable_pulse_1s);
        end
    endtask

    task automatic test_hold_down;
        press(3'b001, 2, 4'b0000, 4'b0000, 1'b0);
        press(3'b100, 40, 4'b0000, 4'b0001, 1'b1);
        repeat (10) @(posedge clk);
    endtask

    task automatic test_reset_mid;
        repeat (3) press(3'b001, 2, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        vec++;
        if (enable_cnt !== 4'b1000) begin
            miss++;
            $display("FAIL set_d: got cnt=%b, want 1000", enable_cnt);
        end
        @(posedge clk); #3;
        btn_up = 1'b1;
        rst    = 1'b1;
        #1;
        vec++;
        if (set_mode !== 1'b0 || enable_cnt !== 4'b1111 || enable_pulse_1s !== 1'b1 ||
            disp_en !== 4'b1111) begin
            miss++;
            $display("FAIL async_reset: got set=%b cnt=%b p1s=%b disp=%b, want 0 1111 1 1111",
                     set_mode, enable_cnt, enable_pulse_1s, disp_en);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        btn_up = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        vec++;
        if (enable_cnt !== 4'b1111 || set_mode !== 1'b0) begin
            miss++;
            $display("FAIL after_reset: got cnt=%b set=%b, want 1111 0", enable_cnt, set_mode);
        end
        blink_walk(4'b0001);
        press(3'b010, 2, 4'b0001, 4'b0000, 1'b0);
    endtask

    initial begin
        test_reset();
        test_run_idle();
        test_set_mi();
        test_collide();
        test_back_to_run();
        test_hold_down();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
